// File: rtl/lpddr2_arb_pkg.sv
// Shared types for the two-master LPDDR2 port arbiter: parameter defaults,
// master ids, FSM states and the read-tracking entry.
package lpddr2_arb_pkg;
    localparam int DEF_ADDR_W  = 27;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_BURST_W = 3;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } state_t;

    typedef struct packed {
        logic                   id;
        logic [DEF_BURST_W-1:0] burstcount;
    } trk_t;
endpackage

// File: rtl/arb_track_fifo.sv
// Read-tracking FIFO: one entry per accepted read (issuing master, burst length).
// A push is honoured while full if a pop happens in the same cycle.
module arb_track_fifo
    import lpddr2_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic i_push,
    input  trk_t i_din,
    input  logic i_pop,
    output trk_t o_head,
    output logic o_full,
    output logic o_empty
);
    localparam int AW = $clog2(DEPTH);

    trk_t        r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/lpddr2_port_arbiter.sv
// Two-master arbiter in front of one LPDDR2 Avalon-MM port: zero-latency
// command forwarding, write-burst grant lock and read-return routing.
module lpddr2_port_arbiter
    import lpddr2_arb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int BURST_W         = DEF_BURST_W,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic               m0_burstbegin,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic [DATA_W-1:0]  m0_writedata,
    output logic               m0_waitrequest_n,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic               m0_urgent,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic               m1_burstbegin,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic [DATA_W-1:0]  m1_writedata,
    output logic               m1_waitrequest_n,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [ADDR_W-1:0]  avl_address,
    output logic               avl_read,
    output logic               avl_write,
    output logic               avl_burstbegin,
    output logic [BURST_W-1:0] avl_burstcount,
    output logic [DATA_W-1:0]  avl_writedata,
    input  logic               avl_waitrequest_n,
    input  logic               avl_readdatavalid,
    input  logic [DATA_W-1:0]  avl_readdata,
    output logic               err_rdata
);
    state_t             r_state;
    logic               r_last;
    logic               r_lock;
    logic [BURST_W-1:0] r_wcnt;
    logic [BURST_W-1:0] r_rcnt;
    logic               r_err;

    trk_t               w_head;
    trk_t               w_push_ent;
    logic               w_full, w_empty, w_pop, w_push, w_rd_blk;
    logic               w_el0, w_el1, w_gnt_vld, w_gnt_id;
    logic               w_sel_rd, w_sel_wr, w_cmd, w_acc;
    logic [BURST_W-1:0] w_rcnt_nxt;

    // Pop is known combinationally, so a full FIFO only blocks a read if no slot frees this cycle.
    assign w_rcnt_nxt = r_rcnt + 1'b1;
    assign w_pop      = avl_readdatavalid & ~w_empty & (w_rcnt_nxt == w_head.burstcount);
    assign w_rd_blk   = w_full & ~w_pop;
    assign w_el0      = m0_write | (m0_read & ~w_rd_blk);
    assign w_el1      = m1_write | (m1_read & ~w_rd_blk);

    always_comb begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_lock;
        if (r_state == IDLE) begin
            w_gnt_vld = w_el0 | w_el1;
            if (m0_urgent & w_el0)  w_gnt_id = ID_M0;
            else if (w_el0 & w_el1) w_gnt_id = ~r_last;
            else                    w_gnt_id = w_el0 ? ID_M0 : ID_M1;
        end
    end

    assign w_sel_rd       = w_gnt_id ? m1_read  : m0_read;
    assign w_sel_wr       = w_gnt_id ? m1_write : m0_write;
    assign avl_address    = w_gnt_id ? m1_address    : m0_address;
    assign avl_burstcount = w_gnt_id ? m1_burstcount : m0_burstcount;
    assign avl_writedata  = w_gnt_id ? m1_writedata  : m0_writedata;
    assign avl_read       = iRST_n & w_gnt_vld & (r_state == IDLE) & w_sel_rd & ~w_rd_blk;
    assign avl_write      = iRST_n & w_gnt_vld & w_sel_wr;
    assign avl_burstbegin = iRST_n & w_gnt_vld & (w_gnt_id ? m1_burstbegin : m0_burstbegin);

    assign w_cmd            = avl_read | avl_write;
    assign w_acc            = w_cmd & avl_waitrequest_n;
    assign m0_waitrequest_n = w_acc & (w_gnt_id == ID_M0);
    assign m1_waitrequest_n = w_acc & (w_gnt_id == ID_M1);

    assign m0_readdata      = avl_readdata;
    assign m1_readdata      = avl_readdata;
    assign m0_readdatavalid = iRST_n & avl_readdatavalid & ~w_empty & (w_head.id == ID_M0);
    assign m1_readdatavalid = iRST_n & avl_readdatavalid & ~w_empty & (w_head.id == ID_M1);
    assign err_rdata        = r_err;

    assign w_push            = avl_read & avl_waitrequest_n;
    assign w_push_ent.id         = w_gnt_id;
    assign w_push_ent.burstcount = avl_burstcount;

    arb_track_fifo #(.DEPTH(MAX_OUTSTANDING)) u_track (
        .iCLK    (iCLK),
        .iRST_n  (iRST_n),
        .i_push  (w_push),
        .i_din   (w_push_ent),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= IDLE;
            r_last  <= ID_M1;
            r_lock  <= ID_M0;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_acc) begin
                    if (avl_read || avl_burstcount == BURST_W'(1)) begin
                        r_last <= w_gnt_id;
                    end else begin
                        r_lock  <= w_gnt_id;
                        r_wcnt  <= avl_burstcount - 1'b1;
                        r_state <= WBURST;
                    end
                end
                WBURST: if (w_acc) begin
                    r_wcnt <= r_wcnt - 1'b1;
                    if (r_wcnt == BURST_W'(1)) begin
                        r_state <= IDLE;
                        r_last  <= r_lock;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_rcnt <= '0;
            r_err  <= 1'b0;
        end else if (avl_readdatavalid) begin
            if (w_empty) r_err  <= 1'b1;
            else         r_rcnt <= w_pop ? '0 : w_rcnt_nxt;
        end
    end
endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Bench for lpddr2_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of grants, outstanding reads and returns.
module tb_lpddr2_port_arbiter;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int BW = 3;
    localparam int MO = 8;

    logic iCLK = 1'b0;
    logic iRST_n = 1'b0;
    logic [1:0] rd, wr, bb, wrn, rdv;
    logic [1:0][AW-1:0] addr;
    logic [1:0][BW-1:0] bc;
    logic [1:0][DW-1:0] wd, rdata;
    logic urgent;
    logic [AW-1:0] avl_address;
    logic avl_read, avl_write, avl_burstbegin;
    logic [BW-1:0] avl_burstcount;
    logic [DW-1:0] avl_writedata;
    logic avl_wrn, avl_rdv;
    logic [DW-1:0] avl_rd;
    logic err;

    int checks = 0;
    int errors = 0;

    // Model: who was served last, write-burst ownership, and the ordered list of reads awaiting data.
    bit mdl_last, mdl_busy, mdl_lock, mdl_err;
    int mdl_rem, mdl_rcv;
    int trk_id[$];
    int trk_bc[$];
    bit e_gv, e_g, e_rd, e_wr;
    bit [1:0] e_wrn, e_rdv;

    always #5 iCLK = ~iCLK;

    lpddr2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .MAX_OUTSTANDING(MO)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n),
        .m0_address(addr[0]), .m0_read(rd[0]), .m0_write(wr[0]), .m0_burstbegin(bb[0]),
        .m0_burstcount(bc[0]), .m0_writedata(wd[0]), .m0_waitrequest_n(wrn[0]),
        .m0_readdata(rdata[0]), .m0_readdatavalid(rdv[0]), .m0_urgent(urgent),
        .m1_address(addr[1]), .m1_read(rd[1]), .m1_write(wr[1]), .m1_burstbegin(bb[1]),
        .m1_burstcount(bc[1]), .m1_writedata(wd[1]), .m1_waitrequest_n(wrn[1]),
        .m1_readdata(rdata[1]), .m1_readdatavalid(rdv[1]),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_burstbegin(avl_burstbegin), .avl_burstcount(avl_burstcount),
        .avl_writedata(avl_writedata), .avl_waitrequest_n(avl_wrn),
        .avl_readdatavalid(avl_rdv), .avl_readdata(avl_rd), .err_rdata(err)
    );

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_idle();
        rd = '0; wr = '0; bb = '0; urgent = 1'b0; avl_rdv = 1'b0; avl_wrn = 1'b1;
    endtask

    task automatic do_reset();
        iRST_n = 1'b0;
        set_idle();
        repeat (2) @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
        mdl_last = 1'b1; mdl_busy = 1'b0; mdl_lock = 1'b0; mdl_err = 1'b0;
        mdl_rem = 0; mdl_rcv = 0;
        trk_id.delete(); trk_bc.delete();
    endtask

    function automatic void model_eval();
        bit [1:0] el;
        bit pop, full_blk, pref;
        pop = avl_rdv && trk_id.size() > 0 && (mdl_rcv + 1 == trk_bc[0]);
        full_blk = (trk_id.size() == MO) && !pop;
        if (mdl_busy) begin
            e_gv = 1'b1; e_g = mdl_lock; e_rd = 1'b0; e_wr = wr[mdl_lock];
        end else begin
            el[0] = wr[0] | (rd[0] & !full_blk);
            el[1] = wr[1] | (rd[1] & !full_blk);
            pref = (urgent && el[0]) ? 1'b0 : !mdl_last;
            e_g  = el[pref] ? pref : !pref;
            e_gv = el[0] | el[1];
            e_rd = e_gv & rd[e_g];
            e_wr = e_gv & wr[e_g];
        end
        e_wrn = '0;
        if ((e_rd | e_wr) && avl_wrn) e_wrn[e_g] = 1'b1;
        e_rdv = '0;
        if (avl_rdv && trk_id.size() > 0) e_rdv[trk_id[0]] = 1'b1;
    endfunction

    function automatic void model_commit();
        if (avl_rdv) begin
            if (trk_id.size() == 0) mdl_err = 1'b1;
            else begin
                mdl_rcv++;
                if (mdl_rcv == trk_bc[0]) begin
                    void'(trk_id.pop_front()); void'(trk_bc.pop_front()); mdl_rcv = 0;
                end
            end
        end
        if ((e_rd | e_wr) && avl_wrn) begin
            if (e_rd) begin
                trk_id.push_back(int'(e_g)); trk_bc.push_back(int'(bc[e_g])); mdl_last = e_g;
            end else if (mdl_busy) begin
                mdl_rem--;
                if (mdl_rem == 0) begin mdl_busy = 1'b0; mdl_last = mdl_lock; end
            end else if (bc[e_g] == 1) begin
                mdl_last = e_g;
            end else begin
                mdl_busy = 1'b1; mdl_lock = e_g; mdl_rem = int'(bc[e_g]) - 1;
            end
        end
    endfunction

    task automatic test_reset();
        tick();
        iRST_n = 1'b0; rd = 2'b01; wr = 2'b10; bc = '{default: BW'(1)};
        avl_wrn = 1'b1; avl_rdv = 1'b1;
        #3;
        checks++; if (avl_read !== 1'b0 || avl_write !== 1'b0 || avl_burstbegin !== 1'b0) begin errors++;
            $display("FAIL reset_strobes got rd=%b wr=%b bb=%b want 0 0 0", avl_read, avl_write, avl_burstbegin); end
        checks++; if (wrn !== 2'b00) begin errors++; $display("FAIL reset_waitrequest_n got %b want 00", wrn); end
        checks++; if (rdv !== 2'b00) begin errors++; $display("FAIL reset_readdatavalid got %b want 00", rdv); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err_rdata got %b want 0", err); end
    endtask

    // mode 0: both masters stream single-beat reads; mode 1: mixed reads/write bursts with stalls and urgency.
    task automatic test_traffic(input int mode, input int ncyc, input string nm);
        bit act[2] = '{1'b0, 1'b0};
        bit isw[2];
        int nbc[2];
        int sent[2];
        bit prev_g = 1'b1;
        bit done = 1'b0;
        do_reset();
        for (int c = 0; c < ncyc + 300; c++) begin
            if (c >= ncyc && !act[0] && !act[1] && trk_id.size() == 0) begin done = 1'b1; break; end
            tick();
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && c < ncyc && (mode == 0 || $urandom_range(0, 2) != 0)) begin
                    act[m] = 1'b1; sent[m] = 0;
                    isw[m] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    nbc[m] = (mode == 1) ? $urandom_range(1, 4) : 1;
                    addr[m] = AW'($urandom);
                end
                rd[m] = act[m] & !isw[m];
                wr[m] = act[m] & isw[m];
                bb[m] = act[m] && sent[m] == 0;
                bc[m] = BW'(nbc[m]);
                wd[m] = $urandom;
            end
            urgent  = (mode == 1) && ($urandom_range(0, 7) == 0);
            avl_wrn = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            avl_rdv = (trk_id.size() > 0) && ($urandom_range(0, 1) == 1);
            avl_rd  = $urandom;
            #3;
            model_eval();
            checks++; if (avl_read !== e_rd || avl_write !== e_wr) begin errors++;
                $display("FAIL %s_strobes cyc %0d got rd=%b wr=%b want rd=%b wr=%b", nm, c, avl_read, avl_write, e_rd, e_wr); end
            checks++; if (wrn !== e_wrn) begin errors++;
                $display("FAIL %s_waitrequest_n cyc %0d got %b want %b", nm, c, wrn, e_wrn); end
            checks++; if (rdv !== e_rdv) begin errors++;
                $display("FAIL %s_readdatavalid cyc %0d got %b want %b", nm, c, rdv, e_rdv); end
            if (e_rdv != 2'b00) begin
                checks++; if (rdata[trk_id[0]] !== avl_rd) begin errors++;
                    $display("FAIL %s_readdata cyc %0d got %h want %h", nm, c, rdata[trk_id[0]], avl_rd); end
            end
            if (e_rd | e_wr) begin
                checks++; if (avl_address !== addr[e_g] || avl_burstcount !== bc[e_g] || avl_burstbegin !== bb[e_g]) begin
                    errors++; $display("FAIL %s_cmd cyc %0d got a=%h bc=%0d bb=%b want a=%h bc=%0d bb=%b", nm, c,
                        avl_address, avl_burstcount, avl_burstbegin, addr[e_g], bc[e_g], bb[e_g]); end
            end
            if (e_wr) begin
                checks++; if (avl_writedata !== wd[e_g]) begin errors++;
                    $display("FAIL %s_writedata cyc %0d got %h want %h", nm, c, avl_writedata, wd[e_g]); end
            end
            if (mode == 0 && wrn != 2'b00) begin
                checks++; if (wrn !== (prev_g ? 2'b01 : 2'b10)) begin errors++;
                    $display("FAIL %s_alternation cyc %0d got %b want %b", nm, c, wrn, prev_g ? 2'b01 : 2'b10); end
                prev_g = wrn[1];
            end
            checks++; if (err !== mdl_err) begin errors++;
                $display("FAIL %s_err_rdata cyc %0d got %b want %b", nm, c, err, mdl_err); end
            model_commit();
            for (int m = 0; m < 2; m++) begin
                if (e_wrn[m]) begin
                    if (!isw[m]) act[m] = 1'b0;
                    else begin sent[m]++; if (sent[m] == nbc[m]) act[m] = 1'b0; end
                end
            end
        end
        checks++; if (!done) begin errors++;
            $display("FAIL %s_drain got pending=%0d want 0 within budget", nm, trk_id.size()); end
        tick();
        set_idle();
    endtask

    task automatic test_write_lock();
        do_reset();
        addr[1] = AW'(32'h100); addr[0] = AW'(32'h200);
        tick(); wr = 2'b10; bb = 2'b10; bc[1] = BW'(4); wd[1] = 32'hA1; #3;
        checks++; if (avl_write !== 1'b1 || wrn !== 2'b10) begin errors++;
            $display("FAIL wlock_beat1 got wr=%b wrn=%b want 1 10", avl_write, wrn); end
        for (int b = 2; b <= 4; b++) begin
            tick(); bb = 2'b00; wd[1] = 32'hA0 + b;
            if (b == 2) begin rd[0] = 1'b1; bc[0] = BW'(1); urgent = 1'b1; end
            #3;
            checks++; if (avl_write !== 1'b1 || avl_read !== 1'b0 || wrn !== 2'b10 ||
                          avl_writedata !== 32'hA0 + b || avl_address !== AW'(32'h100)) begin errors++;
                $display("FAIL wlock_beat%0d got wr=%b rd=%b wrn=%b d=%h a=%h want 1 0 10 %h 100", b,
                    avl_write, avl_read, wrn, avl_writedata, avl_address, 32'hA0 + b); end
        end
        tick(); wr = 2'b00; #3;
        checks++; if (avl_read !== 1'b1 || wrn !== 2'b01 || avl_address !== AW'(32'h200)) begin errors++;
            $display("FAIL wlock_m0_after got rd=%b wrn=%b a=%h want 1 01 200", avl_read, wrn, avl_address); end
        tick(); rd = 2'b00; urgent = 1'b0; avl_rdv = 1'b1; avl_rd = 32'hCAFE0001; #3;
        checks++; if (rdv !== 2'b01 || rdata[0] !== 32'hCAFE0001) begin errors++;
            $display("FAIL wlock_return got rdv=%b d=%h want 01 cafe0001", rdv, rdata[0]); end
        tick(); set_idle();
    endtask

    task automatic test_stall();
        logic [DW-1:0] v;
        do_reset();
        addr[0] = AW'(32'h333); addr[1] = AW'(32'h444); bc[0] = BW'(1); bc[1] = BW'(1);
        rd = 2'b01; wr = 2'b10; avl_wrn = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick(); avl_rdv = (s == 4); #3;
            checks++; if (avl_read !== 1'b1 || avl_write !== 1'b0 || avl_address !== AW'(32'h333) ||
                          wrn !== 2'b00 || rdv !== 2'b00) begin errors++;
                $display("FAIL stall_hold%0d got rd=%b wr=%b a=%h wrn=%b rdv=%b want 1 0 333 00 00", s,
                    avl_read, avl_write, avl_address, wrn, rdv); end
        end
        tick(); avl_rdv = 1'b0; avl_wrn = 1'b1; #3;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stall_no_push got err=%b want 1", err); end
        checks++; if (avl_read !== 1'b1 || wrn !== 2'b01) begin errors++;
            $display("FAIL stall_accept got rd=%b wrn=%b want 1 01", avl_read, wrn); end
        tick(); rd = 2'b00; #3;
        checks++; if (avl_write !== 1'b1 || wrn !== 2'b10 || avl_address !== AW'(32'h444)) begin errors++;
            $display("FAIL stall_m1_next got wr=%b wrn=%b a=%h want 1 10 444", avl_write, wrn, avl_address); end
        v = $urandom;
        tick(); wr = 2'b00; avl_rdv = 1'b1; avl_rd = v; #3;
        checks++; if (rdv !== 2'b01 || rdata[0] !== v) begin errors++;
            $display("FAIL stall_return got rdv=%b d=%h want 01 %h", rdv, rdata[0], v); end
        tick(); set_idle();
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < MO; i++) begin
            tick(); rd = 2'b01; bc[0] = BW'(2); addr[0] = AW'(i); #3;
            checks++; if (avl_read !== 1'b1 || wrn !== 2'b01) begin errors++;
                $display("FAIL full_fill%0d got rd=%b wrn=%b want 1 01", i, avl_read, wrn); end
        end
        tick(); wr = 2'b10; bc[1] = BW'(1); addr[1] = AW'(32'h777); #3;
        checks++; if (avl_read !== 1'b0 || avl_write !== 1'b1 || wrn !== 2'b10) begin errors++;
            $display("FAIL full_write_pass got rd=%b wr=%b wrn=%b want 0 1 10", avl_read, avl_write, wrn); end
        tick(); wr = 2'b00; #3;
        checks++; if (avl_read !== 1'b0 || wrn !== 2'b00) begin errors++;
            $display("FAIL full_blocked got rd=%b wrn=%b want 0 00", avl_read, wrn); end
        tick(); avl_rdv = 1'b1; #3;
        checks++; if (rdv !== 2'b01 || avl_read !== 1'b0 || wrn !== 2'b00) begin errors++;
            $display("FAIL full_beat1 got rdv=%b rd=%b wrn=%b want 01 0 00", rdv, avl_read, wrn); end
        tick(); #3;
        checks++; if (rdv !== 2'b01 || avl_read !== 1'b1 || wrn !== 2'b01) begin errors++;
            $display("FAIL full_pop_accept got rdv=%b rd=%b wrn=%b want 01 1 01", rdv, avl_read, wrn); end
        tick(); set_idle();
    endtask

    task automatic test_err();
        do_reset();
        tick(); avl_rdv = 1'b1; avl_rd = $urandom; #3;
        checks++; if (rdv !== 2'b00 || err !== 1'b0) begin errors++;
            $display("FAIL err_drop got rdv=%b err=%b want 00 0", rdv, err); end
        for (int i = 0; i < 4; i++) begin
            tick(); avl_rdv = 1'b0; #3;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky%0d got %b want 1", i, err); end
        end
        tick(); set_idle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        addr[1] = AW'(32'h555); addr[0] = AW'(32'h666);
        tick(); wr = 2'b10; bb = 2'b10; bc[1] = BW'(3); #3;
        checks++; if (wrn !== 2'b10) begin errors++; $display("FAIL mrst_beat1 got wrn=%b want 10", wrn); end
        tick(); bb = 2'b00; #3;
        checks++; if (wrn !== 2'b10) begin errors++; $display("FAIL mrst_beat2 got wrn=%b want 10", wrn); end
        tick(); iRST_n = 1'b0; rd = 2'b01; bc[0] = BW'(1); avl_rdv = 1'b1; #3;
        checks++; if (avl_read !== 1'b0 || avl_write !== 1'b0 || avl_burstbegin !== 1'b0 || wrn !== 2'b00 ||
                      rdv !== 2'b00 || err !== 1'b0) begin errors++;
            $display("FAIL mrst_outputs got rd=%b wr=%b bb=%b wrn=%b rdv=%b err=%b want all 0",
                avl_read, avl_write, avl_burstbegin, wrn, rdv, err); end
        tick(); avl_rdv = 1'b0; iRST_n = 1'b1; bb = 2'b10; #3;
        checks++; if (avl_read !== 1'b1 || wrn !== 2'b01 || avl_address !== AW'(32'h666)) begin errors++;
            $display("FAIL mrst_m0_first got rd=%b wrn=%b a=%h want 1 01 666", avl_read, wrn, avl_address); end
        tick(); set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        addr = '0; bc = '0; wd = '0; avl_rd = '0;
        test_reset();
        test_traffic(0, 60, "rr");
        test_write_lock();
        test_stall();
        test_fifo_full();
        test_err();
        test_reset_mid_burst();
        test_traffic(1, 400, "mix");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
